cdcsync_hs_src: RTL and testbench

- Source-domain controller for a four-phase req/ack CDC handshake.
- Accepts one data word with a valid/ready handshake and holds it on a stable bus.
- Drives a flopped request level into a destination-side cdcsync_l2l.
- Waits for the acknowledge level, returned through a cdcsync_l2l into src_clk, to complete the full 0-1-0 cycle.
- Sits directly upstream of the level synchronizer, so the signal the synchronizer samples is always glitch-free.

---
 rtl/cdcsync_hs_src_if.sv | 23 ++
 rtl/cdcsync_hs_src.sv | 116 +++++++++++
 tb/tb_cdcsync_hs_src.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdcsync_hs_src_if.sv
// Handshake bundle between a word producer, the source-side CDC controller
// and the destination-facing req/ack/data lines.
interface cdcsync_hs_src_if #(
    parameter int DATA_W = 8
);
    logic              src_vld;
    logic [DATA_W-1:0] src_data;
    logic              src_rdy;
    logic              hs_req;
    logic [DATA_W-1:0] hs_data;
    logic              hs_ack;
    logic              done;

    // master: the handshake controller itself; slave: producer plus destination side
    modport master (
        input  src_vld, src_data, hs_ack,
        output src_rdy, hs_req, hs_data, done
    );
    modport slave (
        output src_vld, src_data, hs_ack,
        input  src_rdy, hs_req, hs_data, done
    );
endinterface

// File: rtl/cdcsync_hs_src.sv
// Source side of a four-phase req/ack CDC handshake: captures one word, raises a
// flopped request level and waits for the full 0-1-0 acknowledge cycle.
module cdcsync_hs_src #(
    parameter int DATA_W = 8,
    parameter int TO_W   = 16
) (
    input  logic            src_clk,
    input  logic            src_rst,
    cdcsync_hs_src_if.master bus,
    input  logic [TO_W-1:0] cfg_timeout,
    output logic            err_timeout,
    input  logic            err_clr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              hs_req_reg, hs_req_next;
    logic [DATA_W-1:0] hs_data_reg, hs_data_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [TO_W-1:0]   cnt_reg, cnt_next;
    logic              rdy;
    logic              ack_absent;
    logic              to_hit;

    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            state_reg   <= IDLE;
            hs_req_reg  <= 1'b0;
            hs_data_reg <= '0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            hs_req_reg  <= hs_req_next;
            hs_data_reg <= hs_data_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        hs_req_next  = hs_req_reg;
        hs_data_next = hs_data_reg;
        done_next    = 1'b0;
        cnt_next     = cnt_reg;
        rdy          = 1'b0;
        ack_absent   = 1'b0;
        to_hit       = 1'b0;

        case (state_reg)
            IDLE: begin
                // a stale ack left high by the destination blocks new words
                rdy = !bus.hs_ack;
                if (bus.src_vld && !bus.hs_ack) begin
                    hs_data_next = bus.src_data;
                    hs_req_next  = 1'b1;
                    cnt_next     = '0;
                    state_next   = REQ;
                end
            end
            REQ: begin
                if (bus.hs_ack) begin
                    hs_req_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = RELEASE;
                end else begin
                    ack_absent = 1'b1;
                end
            end
            RELEASE: begin
                if (!bus.hs_ack) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    ack_absent = 1'b1;
                end
            end
            default: begin
                hs_req_next = 1'b0;
                state_next  = IDLE;
            end
        endcase

        // timeout only reports; the handshake keeps waiting regardless
        if (ack_absent && (cfg_timeout != '0)) begin
            if (cnt_reg != '1) begin
                cnt_next = cnt_reg + TO_W'(1);
            end
            to_hit = (cnt_reg == cfg_timeout - TO_W'(1));
        end

        if (to_hit) begin
            err_next = 1'b1;
        end else if (err_clr) begin
            err_next = 1'b0;
        end else begin
            err_next = err_reg;
        end
    end

    assign bus.src_rdy = rdy;
    assign bus.hs_req  = hs_req_reg;
    assign bus.hs_data = hs_data_reg;
    assign bus.done    = done_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_cdcsync_hs_src.sv
// Bench for cdcsync_hs_src: transaction-level reference model, programmable ack
// loop-back, table-driven transfers, directed corner cases and random traffic.
module tb_cdcsync_hs_src;
    localparam int DATA_W = 8;
    localparam int TO_W   = 16;

    logic            src_clk = 1'b0;
    logic            src_rst = 1'b0;
    logic [TO_W-1:0] cfg_timeout;
    logic            err_clr;
    logic            err_timeout;

    cdcsync_hs_src_if #(.DATA_W(DATA_W)) bus ();

    cdcsync_hs_src #(.DATA_W(DATA_W), .TO_W(TO_W)) dut (
        .src_clk     (src_clk),
        .src_rst     (src_rst),
        .bus         (bus),
        .cfg_timeout (cfg_timeout),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    always #5 src_clk = ~src_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: transfer outstanding, request level owed, wait length of current phase
    bit         m_busy, m_req, m_done, m_err;
    logic [7:0] m_data;
    int         m_wait;

    bit ack_loop;
    int ack_dly;
    int lag;

    int         acc_cnt, done_cnt;
    logic [7:0] rise_q[$];
    bit         prev_req;

    typedef struct {
        logic [7:0] data;
        int         cfg;
        int         dly;
        bit         exp_err;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit vld_s, ack_s, clr_s, rdy_e, set_s;
        logic [7:0] d_s;
        int cfg_s;
        @(negedge src_clk);
        vld_s = bus.src_vld;
        d_s   = bus.src_data;
        ack_s = bus.hs_ack;
        clr_s = err_clr;
        cfg_s = int'(cfg_timeout);
        rdy_e = !m_busy && !ack_s;
        chk("src_rdy", bus.src_rdy, rdy_e);
        set_s  = 1'b0;
        m_done = 1'b0;
        if (vld_s && rdy_e) begin
            m_busy = 1'b1;
            m_req  = 1'b1;
            m_data = d_s;
            m_wait = 0;
            acc_cnt++;
        end else if (m_busy && m_req) begin
            if (ack_s) begin
                m_req  = 1'b0;
                m_wait = 0;
            end else begin
                m_wait++;
                if (cfg_s != 0 && m_wait == cfg_s) set_s = 1'b1;
            end
        end else if (m_busy) begin
            if (!ack_s) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_wait++;
                if (cfg_s != 0 && m_wait == cfg_s) set_s = 1'b1;
            end
        end
        if (set_s) m_err = 1'b1;
        else if (clr_s) m_err = 1'b0;

        @(posedge src_clk);
        #1;
        chk("hs_req", bus.hs_req, m_req);
        chk("done", bus.done, m_done);
        chk("err_timeout", err_timeout, m_err);
        chk("hs_data", bus.hs_data, m_data);
        if (bus.hs_req && !prev_req) rise_q.push_back(bus.hs_data);
        prev_req = bus.hs_req;
        if (bus.done) done_cnt++;
        if (ack_loop) begin
            if (bus.hs_ack != bus.hs_req) begin
                lag++;
                if (lag >= ack_dly) begin
                    bus.hs_ack = bus.hs_req;
                    lag = 0;
                end
            end else begin
                lag = 0;
            end
        end
    endtask

    task automatic apply_reset();
        src_rst = 1'b1;
        #1;
        m_busy = 0; m_req = 0; m_done = 0; m_err = 0; m_data = '0; m_wait = 0;
        prev_req = 0; lag = 0;
        chk("rst_hs_req", bus.hs_req, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_hs_data", bus.hs_data, 0);
        repeat (2) @(posedge src_clk);
        #1;
        src_rst = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] d, input int budget, input bit noise);
        int a0 = acc_cnt;
        int d0 = done_cnt;
        int n  = 0;
        bus.src_vld  = 1'b1;
        bus.src_data = d;
        while (acc_cnt == a0 && n < budget) begin tick(); n++; end
        bus.src_vld = 1'b0;
        while (done_cnt == d0 && n < budget) begin
            if (noise) begin
                bus.src_vld  = 1'($urandom_range(0, 1));
                bus.src_data = 8'($urandom);
            end
            tick();
            n++;
        end
        bus.src_vld = 1'b0;
        chk("xfer_done", done_cnt - d0, 1);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b[3];
        int n, idx, a0, d0, r0;
        logic [7:0] d;

        b2b = '{8'h11, 8'h22, 8'h33};
        tbl[0] = '{8'h3C, 3, 3,   1'b0};
        tbl[1] = '{8'hC3, 2, 3,   1'b1};
        tbl[2] = '{8'h5A, 1, 1,   1'b0};
        tbl[3] = '{8'hFF, 4, 6,   1'b1};
        tbl[4] = '{8'h77, 0, 500, 1'b0};
        tbl[5] = '{8'h96, 1, 2,   1'b1};

        bus.src_vld = 0; bus.src_data = 0; bus.hs_ack = 0;
        err_clr = 0; cfg_timeout = 0;
        ack_loop = 1; ack_dly = 3; acc_cnt = 0; done_cnt = 0;
        @(posedge src_clk);
        #1;
        apply_reset();
        chk("rst_src_rdy", bus.src_rdy, 1);

        // basic transfer with 3-cycle loop-back each way
        d0 = done_cnt;
        bus.src_vld = 1; bus.src_data = 8'hA5;
        tick();
        bus.src_vld = 0;
        chk("basic_req_rise", bus.hs_req, 1);
        n = 0;
        while (!bus.done && n < 50) begin tick(); n++; end
        chk("basic_latency", n, 6);
        chk("basic_done_cnt", done_cnt - d0, 1);
        chk("basic_rdy_after", bus.src_rdy, 1);
        chk("basic_data", rise_q[$], 8'hA5);
        tick();

        // back-to-back with src_vld held high
        r0 = rise_q.size(); a0 = acc_cnt; d0 = done_cnt; idx = 0; n = 0;
        bus.src_vld = 1; bus.src_data = b2b[0];
        while (done_cnt < d0 + 3 && n < 200) begin
            tick(); n++;
            if (acc_cnt != a0) begin
                a0 = acc_cnt; idx++;
                if (idx < 3) bus.src_data = b2b[idx];
                else bus.src_vld = 0;
            end
        end
        bus.src_vld = 0;
        chk("b2b_count", rise_q.size() - r0, 3);
        for (int i = 0; i < 3; i++) chk("b2b_order", rise_q[r0 + i], b2b[i]);

        // table-driven transfers
        for (int i = 0; i < 6; i++) begin
            cfg_timeout = TO_W'(tbl[i].cfg);
            ack_dly = tbl[i].dly;
            clear_err();
            xfer(tbl[i].data, 2000, 1'b0);
            chk("tbl_err", err_timeout, tbl[i].exp_err);
            chk("tbl_data", rise_q[$], tbl[i].data);
        end

        // timeout: ack withheld, then returned, then cleared
        cfg_timeout = 10; clear_err();
        ack_loop = 0; bus.hs_ack = 0;
        bus.src_vld = 1; bus.src_data = 8'h4D;
        tick();
        bus.src_vld = 0;
        n = 0;
        while (!err_timeout && n < 30) begin tick(); n++; end
        chk("to_cycles", n, 10);
        chk("to_req_hold", bus.hs_req, 1);
        ack_loop = 1; ack_dly = 2; lag = 0; d0 = done_cnt; n = 0;
        while (done_cnt == d0 && n < 50) begin tick(); n++; end
        chk("to_completes", done_cnt - d0, 1);
        chk("to_sticky", err_timeout, 1);
        clear_err();
        chk("to_clr", err_timeout, 0);

        // set/clear collision: set must win
        cfg_timeout = 5;
        ack_loop = 0; bus.hs_ack = 0;
        bus.src_vld = 1; bus.src_data = 8'hB7;
        tick();
        bus.src_vld = 0;
        repeat (4) tick();
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("coll_err", err_timeout, 1);
        ack_loop = 1; ack_dly = 3; lag = 0; d0 = done_cnt; n = 0;
        while (done_cnt == d0 && n < 50) begin tick(); n++; end
        chk("coll_done", done_cnt - d0, 1);
        clear_err();

        // stale ack across a reset in REQ
        cfg_timeout = 0;
        ack_loop = 0; bus.hs_ack = 0;
        bus.src_vld = 1; bus.src_data = 8'hE1;
        tick();
        bus.src_vld = 0;
        tick();
        chk("stale_in_req", bus.hs_req, 1);
        bus.hs_ack = 1;
        apply_reset();
        r0 = rise_q.size();
        bus.src_vld = 1; bus.src_data = 8'hE2;
        repeat (5) tick();
        chk("stale_no_req", rise_q.size() - r0, 0);
        chk("stale_rdy_low", bus.src_rdy, 0);
        bus.hs_ack = 0; ack_loop = 1; ack_dly = 3; lag = 0;
        xfer(8'hE2, 100, 1'b0);
        chk("stale_first_data", rise_q[$], 8'hE2);
        chk("stale_one_rise", rise_q.size() - r0, 1);

        // random traffic against the model
        for (int i = 0; i < 40; i++) begin
            cfg_timeout = TO_W'($urandom_range(0, 8));
            ack_dly = int'($urandom_range(1, 10));
            if ($urandom_range(0, 1) == 1) clear_err();
            repeat ($urandom_range(0, 3)) tick();
            d = 8'($urandom);
            xfer(d, 300, 1'b1);
            chk("rnd_data", rise_q[$], d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
